// File: rtl/vocoder_mix_scheduler_pkg.sv
// vocoder_mix_scheduler_pkg: shared constants and types for the vocoder mixer
package vocoder_mix_scheduler_pkg;
  localparam int N_FILTERS = 16;
  localparam int MIX_PRODUCT_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SCALE} mix_state_t;
  function automatic int mix_acc_width(input int n);
    return MIX_PRODUCT_WIDTH + $clog2(n);
  endfunction
endpackage

// File: rtl/vocoder_mix_scheduler_mix_multiplier.sv
// mix_multiplier: signed 32x32 multiplier with LAT register stages and a valid bit
module mix_multiplier #(
  parameter int LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic signed [63:0] p_o,
  output logic               valid_o,
  output logic               any_o
);
  logic signed [63:0] p_q [LAT];
  logic [LAT-1:0] v_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) v_q <= '0;
    else v_q <= LAT'({v_q, valid_i});
  // data stages carry no reset so the tools can map them into a DSP block
  always_ff @(posedge clk_i) begin
    p_q[0] <= 64'(a_i) * 64'(b_i);
    for (int s = 1; s < LAT; s++) p_q[s] <= p_q[s-1];
  end
  assign p_o = p_q[LAT-1];
  assign valid_o = v_q[LAT-1];
  assign any_o = |v_q;
endmodule

// File: rtl/vocoder_mix_scheduler.sv
// vocoder_mix_scheduler: sequences one shared multiplier to mix carrier x envelope channels
// Define VOCODER_CHANNEL_MASK_EN to add ch_mask_in and skip masked channels.
module vocoder_mix_scheduler
  import vocoder_mix_scheduler_pkg::*;
#(
  parameter int N_CH = N_FILTERS,
  parameter int MULT_LATENCY = 2,
  parameter int OUT_SHIFT = 24,
  parameter int OUT_WIDTH = 24
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  input  logic [N_CH-1:0][31:0]       carrier_in,
  input  logic [N_CH-1:0][31:0]       envelope_in,
`ifdef VOCODER_CHANNEL_MASK_EN
  input  logic [N_CH-1:0]             ch_mask_in,
`endif
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        valid_out,
  output logic                        busy_out,
  output logic                        overrun_out
);
  localparam int AW = mix_acc_width(N_CH);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  mix_state_t state_q, state_d;
  logic [N_CH-1:0][31:0] car_q, car_d, env_q, env_d;
  logic [N_CH-1:0] pend_q, pend_d, sel, mask;
  logic signed [AW-1:0] acc_q, acc_d, shifted;
  logic signed [OUT_WIDTH-1:0] sample_q, sample_d;
  logic valid_q, valid_d, overrun_q, overrun_d, issue, m_valid, m_any;
  logic [31:0] a, b;
  logic signed [63:0] prod;
`ifdef VOCODER_CHANNEL_MASK_EN
  assign mask = ch_mask_in;
`else
  assign mask = '1;
`endif
  mix_multiplier #(.LAT(MULT_LATENCY)) u_mult (
    .clk_i(clk_in), .rst_i(rst_in), .valid_i(issue), .a_i($signed(a)), .b_i($signed(b)),
    .p_o(prod), .valid_o(m_valid), .any_o(m_any)
  );
  // pend_q holds the channels still to issue; the lowest set bit goes next
  always_comb begin
    state_d = state_q;
    car_d = car_q;
    env_d = env_q;
    pend_d = pend_q;
    sample_d = sample_q;
    valid_d = 1'b0;
    issue = 1'b0;
    sel = pend_q & (~pend_q + N_CH'(1));
    a = '0;
    b = '0;
    for (int i = 0; i < N_CH; i++) begin
      a = a | (sel[i] ? car_q[i] : 32'd0);
      b = b | (sel[i] ? env_q[i] : 32'd0);
    end
    shifted = acc_q >>> OUT_SHIFT;
    acc_d = m_valid ? acc_q + AW'(prod) : acc_q;
    overrun_d = valid_in && (state_q != IDLE || valid_q);
    case (state_q)
      IDLE:
        if (valid_in && !valid_q) begin
          car_d = carrier_in;
          env_d = envelope_in;
          pend_d = mask;
          acc_d = '0;
          // an empty mask drains an empty pipeline for one cycle before scaling
          state_d = |mask ? ISSUE : DRAIN;
        end
      ISSUE: begin
        issue = 1'b1;
        pend_d = pend_q & ~sel;
        state_d = pend_d == '0 ? DRAIN : ISSUE;
      end
      DRAIN: state_d = m_any ? DRAIN : SCALE;
      SCALE: begin
        sample_d = shifted > SAT_MAX ? SAT_MAX[OUT_WIDTH-1:0] :
                   shifted < SAT_MIN ? SAT_MIN[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      car_q <= '0;
      env_q <= '0;
      pend_q <= '0;
      acc_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q <= car_d;
      env_q <= env_d;
      pend_q <= pend_d;
      acc_q <= acc_d;
      sample_q <= sample_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  assign sample_out = sample_q;
  assign valid_out = valid_q;
  assign overrun_out = overrun_q;
  assign busy_out = state_q != IDLE || valid_q;
endmodule
